// File: rtl/twos_to_bipolar_serializer_pkg.sv
// twos_to_bipolar_pkg: shared types and the two's-complement to bipolar lane conversion.
// Rev 1.0
`default_nettype none

package twos_to_bipolar_pkg;

  localparam int MAX_BITS = 32;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  typedef enum logic [0:0] {
    LSB_FIRST = 1'b0,
    MSB_FIRST = 1'b1
  } plane_order_t;

  typedef struct packed {
    logic [MAX_BITS-1:0] p;
    logic [MAX_BITS-1:0] n;
    logic                zero;
  } bipolar_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // x holds an in_bits-wide word in its low bits; p/n come back truncated to in_bits-1.
  function automatic bipolar_t to_bipolar(input logic [MAX_BITS-1:0] x, input int unsigned in_bits);
    bipolar_t            r;
    logic [MAX_BITS-1:0] in_mask;
    logic [MAX_BITS-1:0] out_mask;
    logic [MAX_BITS-1:0] xm;
    logic [MAX_BITS-1:0] nx;
    in_mask  = (MAX_BITS'(1) << in_bits) - MAX_BITS'(1);
    out_mask = (MAX_BITS'(1) << (in_bits - 1)) - MAX_BITS'(1);
    xm       = x & in_mask;
    nx       = (~xm + MAX_BITS'(1)) & in_mask;
    r        = '0;
    r.zero   = (xm == '0);
    if (!r.zero) begin
      if (xm[in_bits-1]) begin
        r.p = ~nx & out_mask;
        r.n = nx & out_mask;
      end else begin
        r.p = xm & out_mask;
        r.n = ~xm & out_mask;
      end
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/twos_to_bipolar_serializer_if.sv
// twos_to_bipolar_serializer_if: input word handshake and output bit-plane handshake.
// Rev 1.0
`default_nettype none

interface twos_to_bipolar_serializer_if #(
  parameter int IN_BITS   = 4,
  parameter int NUM_LANES = 8
);
  localparam int OUT_BITS = IN_BITS - 1;
  localparam int IDX_W    = int'(twos_to_bipolar_pkg::idx_width(OUT_BITS));

  logic                                     in_valid;
  logic                                     in_ready;
  logic signed [NUM_LANES-1:0][IN_BITS-1:0] in_data;
  logic                                     in_msb_first;
  logic                                     out_valid;
  logic                                     out_ready;
  logic        [NUM_LANES-1:0]              out_p;
  logic        [NUM_LANES-1:0]              out_n;
  logic        [NUM_LANES-1:0]              out_zero;
  logic        [IDX_W-1:0]                  out_plane_idx;
  logic                                     out_last;

  modport master (
    output in_valid, in_data, in_msb_first, out_ready,
    input  in_ready, out_valid, out_p, out_n, out_zero, out_plane_idx, out_last
  );

  modport slave (
    input  in_valid, in_data, in_msb_first, out_ready,
    output in_ready, out_valid, out_p, out_n, out_zero, out_plane_idx, out_last
  );

endinterface

`default_nettype wire

// File: rtl/twos_to_bipolar_serializer_buffer.sv
// bipolar_plane_buffer: per-lane p/n/zero storage with indexed bit-plane select.
// Rev 1.0
`default_nettype none

module bipolar_plane_buffer #(
  parameter int NUM_LANES = 8,
  parameter int OUT_BITS  = 3,
  parameter int IDX_W     = 2
) (
  input  wire logic                               clk,
  input  wire logic                               rst,
  input  wire logic                               load_i,
  input  wire logic [NUM_LANES-1:0][OUT_BITS-1:0] p_i,
  input  wire logic [NUM_LANES-1:0][OUT_BITS-1:0] n_i,
  input  wire logic [NUM_LANES-1:0]               zero_i,
  input  wire logic [IDX_W-1:0]                   idx_i,
  output logic      [NUM_LANES-1:0]               plane_p_o,
  output logic      [NUM_LANES-1:0]               plane_n_o,
  output logic      [NUM_LANES-1:0]               zero_o
);

  logic [NUM_LANES-1:0][OUT_BITS-1:0] p_q;
  logic [NUM_LANES-1:0][OUT_BITS-1:0] n_q;
  logic [NUM_LANES-1:0]               zero_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q    <= '0;
      n_q    <= '0;
      zero_q <= '0;
    end else if (load_i) begin
      p_q    <= p_i;
      n_q    <= n_i;
      zero_q <= zero_i;
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_sel
    assign plane_p_o[l] = p_q[l][idx_i];
    assign plane_n_o[l] = n_q[l][idx_i];
  end

  assign zero_o = zero_q;

endmodule

`default_nettype wire

// File: rtl/twos_to_bipolar_serializer.sv
// twos_to_bipolar_serializer: converts lane words to bipolar p/n and streams one bit-plane per cycle.
// Rev 1.0
`default_nettype none

module twos_to_bipolar_serializer
  import twos_to_bipolar_pkg::*;
#(
  parameter int IN_BITS   = 4,
  parameter int NUM_LANES = 8
) (
  input wire logic                    clk,
  input wire logic                    rst,
  twos_to_bipolar_serializer_if.slave bus
);

  localparam int OUT_BITS = IN_BITS - 1;
  localparam int IDX_W    = int'(idx_width(OUT_BITS));
  localparam logic [IDX_W-1:0] c_TOP_IDX  = IDX_W'(OUT_BITS - 1);
  localparam logic [IDX_W-1:0] c_PEN_IDX  = IDX_W'(OUT_BITS - 2);
  localparam logic [IDX_W-1:0] c_ONE      = IDX_W'(1);
  localparam logic             c_ONE_PLANE = (OUT_BITS == 1);

  state_t                             state_q;
  plane_order_t                       order_q;
  logic [IDX_W-1:0]                   idx_q;
  logic                               last_q;

  logic [NUM_LANES-1:0][OUT_BITS-1:0] w_p_d;
  logic [NUM_LANES-1:0][OUT_BITS-1:0] w_n_d;
  logic [NUM_LANES-1:0]               w_zero_d;
  logic [NUM_LANES-1:0]               w_plane_p;
  logic [NUM_LANES-1:0]               w_plane_n;
  logic [NUM_LANES-1:0]               w_zero;
  logic                               w_out_fire;
  logic                               w_handoff;
  logic                               w_in_ready;
  logic                               w_accept;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    bipolar_t w_conv;
    logic     w_unused_bits;
    assign w_conv        = to_bipolar(MAX_BITS'(bus.in_data[l]), IN_BITS);
    assign w_p_d[l]      = w_conv.p[OUT_BITS-1:0];
    assign w_n_d[l]      = w_conv.n[OUT_BITS-1:0];
    assign w_zero_d[l]   = w_conv.zero;
    assign w_unused_bits = ^{w_conv.p[MAX_BITS-1:OUT_BITS], w_conv.n[MAX_BITS-1:OUT_BITS]};
  end

  // Final-plane handoff reopens the input in the same cycle so transactions chain without a bubble.
  assign w_out_fire = (state_q == ST_STREAM) && bus.out_ready;
  assign w_handoff  = w_out_fire && last_q;
  assign w_in_ready = (state_q == ST_IDLE) || w_handoff;
  assign w_accept   = bus.in_valid && w_in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      order_q <= LSB_FIRST;
      idx_q   <= '0;
      last_q  <= 1'b0;
    end else if (w_accept) begin
      state_q <= ST_STREAM;
      order_q <= bus.in_msb_first ? MSB_FIRST : LSB_FIRST;
      idx_q   <= bus.in_msb_first ? c_TOP_IDX : '0;
      last_q  <= c_ONE_PLANE;
    end else if (w_handoff) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      last_q  <= 1'b0;
    end else if (w_out_fire) begin
      if (order_q == MSB_FIRST) begin
        idx_q  <= idx_q - c_ONE;
        last_q <= (idx_q == c_ONE);
      end else begin
        idx_q  <= idx_q + c_ONE;
        last_q <= (idx_q == c_PEN_IDX);
      end
    end
  end

  bipolar_plane_buffer #(
    .NUM_LANES (NUM_LANES),
    .OUT_BITS  (OUT_BITS),
    .IDX_W     (IDX_W)
  ) u_buffer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (w_accept),
    .p_i       (w_p_d),
    .n_i       (w_n_d),
    .zero_i    (w_zero_d),
    .idx_i     (idx_q),
    .plane_p_o (w_plane_p),
    .plane_n_o (w_plane_n),
    .zero_o    (w_zero)
  );

  assign bus.in_ready      = w_in_ready;
  assign bus.out_valid     = (state_q == ST_STREAM);
  assign bus.out_p         = w_plane_p;
  assign bus.out_n         = w_plane_n;
  assign bus.out_zero      = w_zero;
  assign bus.out_plane_idx = idx_q;
  assign bus.out_last      = last_q;

endmodule

`default_nettype wire

// File: tb/tb_twos_to_bipolar_serializer.sv
// tb_twos_to_bipolar_serializer: directed checks of conversion, plane order, chaining, backpressure, reset.
// Rev 1.0
`default_nettype none

module tb_twos_to_bipolar_serializer;

  localparam int IN_BITS   = 4;
  localparam int NUM_LANES = 4;
  localparam int OUT_BITS  = 3;

  typedef logic [NUM_LANES-1:0][OUT_BITS-1:0] lanes_t;

  // Lanes {3,-3,0,5} (lane0 first); packed constants below are lane3..lane0.
  localparam logic [15:0] A_DATA = 16'h50D3;
  localparam lanes_t      A_P    = {3'b101, 3'b000, 3'b100, 3'b011};
  localparam lanes_t      A_N    = {3'b010, 3'b000, 3'b011, 3'b100};
  localparam logic [3:0]  A_Z    = 4'b0100;
  // Lanes {-8,-1,7,1}.
  localparam logic [15:0] B_DATA = 16'h17F8;
  localparam lanes_t      B_P    = {3'b001, 3'b111, 3'b110, 3'b111};
  localparam lanes_t      B_N    = {3'b110, 3'b000, 3'b001, 3'b000};
  localparam logic [3:0]  B_Z    = 4'b0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  twos_to_bipolar_serializer_if #(.IN_BITS(IN_BITS), .NUM_LANES(NUM_LANES)) bus ();

  twos_to_bipolar_serializer #(.IN_BITS(IN_BITS), .NUM_LANES(NUM_LANES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [NUM_LANES-1:0] plane(input lanes_t v, input int idx);
    logic [NUM_LANES-1:0] r;
    for (int l = 0; l < NUM_LANES; l++) r[l] = v[l][idx];
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_msb_first = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got %b want 0", bus.out_valid); end
    total++; if (bus.out_p !== 4'h0) begin bad++; $display("FAIL rst_p got %b want 0000", bus.out_p); end
    total++; if (bus.out_n !== 4'h0) begin bad++; $display("FAIL rst_n got %b want 0000", bus.out_n); end
    total++; if (bus.out_zero !== 4'h0) begin bad++; $display("FAIL rst_zero got %b want 0000", bus.out_zero); end
    total++; if (bus.out_plane_idx !== 2'd0) begin bad++; $display("FAIL rst_idx got %0d want 0", bus.out_plane_idx); end
    total++; if (bus.out_last !== 1'b0) begin bad++; $display("FAIL rst_last got %b want 0", bus.out_last); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_lsb_first();
    bus.in_data = A_DATA;
    bus.in_msb_first = 1'b0;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL lsb_accept_ready got %b want 1", bus.in_ready); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data = 16'hFFFF;
    for (int k = 0; k < OUT_BITS; k++) begin
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL lsb_valid k=%0d got %b want 1", k, bus.out_valid); end
      total++; if (bus.out_plane_idx !== 2'(k)) begin bad++; $display("FAIL lsb_idx k=%0d got %0d want %0d", k, bus.out_plane_idx, k); end
      total++; if (bus.out_p !== plane(A_P, k)) begin bad++; $display("FAIL lsb_p k=%0d got %b want %b", k, bus.out_p, plane(A_P, k)); end
      total++; if (bus.out_n !== plane(A_N, k)) begin bad++; $display("FAIL lsb_n k=%0d got %b want %b", k, bus.out_n, plane(A_N, k)); end
      total++; if (bus.out_zero !== A_Z) begin bad++; $display("FAIL lsb_zero k=%0d got %b want %b", k, bus.out_zero, A_Z); end
      total++; if (bus.out_last !== (k == OUT_BITS - 1)) begin bad++; $display("FAIL lsb_last k=%0d got %b want %b", k, bus.out_last, k == OUT_BITS - 1); end
      total++; if (bus.in_ready !== (k == OUT_BITS - 1)) begin bad++; $display("FAIL lsb_in_ready k=%0d got %b want %b", k, bus.in_ready, k == OUT_BITS - 1); end
      @(posedge clk); #1;
    end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL lsb_idle got %b want 0", bus.out_valid); end
  endtask

  task automatic test_msb_first();
    bus.in_data = A_DATA;
    bus.in_msb_first = 1'b1;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_msb_first = 1'b0;
    for (int k = 0; k < OUT_BITS; k++) begin
      int idx = OUT_BITS - 1 - k;
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL msb_valid k=%0d got %b want 1", k, bus.out_valid); end
      total++; if (bus.out_plane_idx !== 2'(idx)) begin bad++; $display("FAIL msb_idx k=%0d got %0d want %0d", k, bus.out_plane_idx, idx); end
      total++; if (bus.out_p !== plane(A_P, idx)) begin bad++; $display("FAIL msb_p k=%0d got %b want %b", k, bus.out_p, plane(A_P, idx)); end
      total++; if (bus.out_n !== plane(A_N, idx)) begin bad++; $display("FAIL msb_n k=%0d got %b want %b", k, bus.out_n, plane(A_N, idx)); end
      total++; if (bus.out_last !== (idx == 0)) begin bad++; $display("FAIL msb_last k=%0d got %b want %b", k, bus.out_last, idx == 0); end
      @(posedge clk); #1;
    end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL msb_idle got %b want 0", bus.out_valid); end
  endtask

  task automatic test_extremes();
    bus.in_data = B_DATA;
    bus.in_msb_first = 1'b0;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int k = 0; k < OUT_BITS; k++) begin
      total++; if (bus.out_p !== plane(B_P, k)) begin bad++; $display("FAIL ext_p k=%0d got %b want %b", k, bus.out_p, plane(B_P, k)); end
      total++; if (bus.out_n !== plane(B_N, k)) begin bad++; $display("FAIL ext_n k=%0d got %b want %b", k, bus.out_n, plane(B_N, k)); end
      total++; if (bus.out_zero !== B_Z) begin bad++; $display("FAIL ext_zero k=%0d got %b want %b", k, bus.out_zero, B_Z); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    bus.in_data = A_DATA;
    bus.in_msb_first = 1'b0;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_data = B_DATA;
    bus.in_msb_first = 1'b1;
    for (int c = 0; c < 2 * OUT_BITS; c++) begin
      int     idx;
      lanes_t ep;
      lanes_t en;
      idx = (c < OUT_BITS) ? c : (2 * OUT_BITS - 1 - c);
      ep  = (c < OUT_BITS) ? A_P : B_P;
      en  = (c < OUT_BITS) ? A_N : B_N;
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid c=%0d got %b want 1", c, bus.out_valid); end
      total++; if (bus.out_plane_idx !== 2'(idx)) begin bad++; $display("FAIL b2b_idx c=%0d got %0d want %0d", c, bus.out_plane_idx, idx); end
      total++; if (bus.out_p !== plane(ep, idx)) begin bad++; $display("FAIL b2b_p c=%0d got %b want %b", c, bus.out_p, plane(ep, idx)); end
      total++; if (bus.out_n !== plane(en, idx)) begin bad++; $display("FAIL b2b_n c=%0d got %b want %b", c, bus.out_n, plane(en, idx)); end
      total++; if (bus.in_ready !== (c == OUT_BITS - 1 || c == 2 * OUT_BITS - 1)) begin bad++; $display("FAIL b2b_in_ready c=%0d got %b", c, bus.in_ready); end
      @(posedge clk); #1;
      if (c == OUT_BITS - 1) bus.in_valid = 1'b0;
    end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL b2b_idle got %b want 0", bus.out_valid); end
  endtask

  task automatic test_backpressure();
    logic [15:0] pat;
    int          k;
    pat = 16'b1111_1111_1110_1001;
    k = 0;
    bus.in_data = A_DATA;
    bus.in_msb_first = 1'b0;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int c = 0; c < 16 && k < OUT_BITS; c++) begin
      bus.out_ready = pat[c];
      #1;
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid c=%0d got %b want 1", c, bus.out_valid); end
      total++; if (bus.out_plane_idx !== 2'(k)) begin bad++; $display("FAIL bp_idx c=%0d got %0d want %0d", c, bus.out_plane_idx, k); end
      total++; if (bus.out_p !== plane(A_P, k)) begin bad++; $display("FAIL bp_p c=%0d got %b want %b", c, bus.out_p, plane(A_P, k)); end
      total++; if (bus.in_ready !== (k == OUT_BITS - 1 && pat[c])) begin bad++; $display("FAIL bp_in_ready c=%0d got %b want %b", c, bus.in_ready, k == OUT_BITS - 1 && pat[c]); end
      if (pat[c]) k++;
      @(posedge clk); #1;
    end
    total++; if (k !== OUT_BITS) begin bad++; $display("FAIL bp_planes got %0d want %0d", k, OUT_BITS); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_idle got %b want 0", bus.out_valid); end
    bus.out_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    bus.in_data = B_DATA;
    bus.in_msb_first = 1'b0;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (bus.out_plane_idx !== 2'd1) begin bad++; $display("FAIL rm_idx got %0d want 1", bus.out_plane_idx); end
    total++; if (bus.out_p !== plane(B_P, 1)) begin bad++; $display("FAIL rm_p got %b want %b", bus.out_p, plane(B_P, 1)); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rm_valid got %b want 0", bus.out_valid); end
    total++; if ({bus.out_p, bus.out_n, bus.out_zero} !== 12'h000) begin bad++; $display("FAIL rm_data got %h want 000", {bus.out_p, bus.out_n, bus.out_zero}); end
    total++; if ({bus.out_plane_idx, bus.out_last} !== 3'b000) begin bad++; $display("FAIL rm_idx_last got %b want 000", {bus.out_plane_idx, bus.out_last}); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rm_in_ready got %b want 1", bus.in_ready); end
    bus.in_data = A_DATA;
    bus.in_msb_first = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL rm_fresh_valid got %b want 1", bus.out_valid); end
    total++; if (bus.out_plane_idx !== 2'd2) begin bad++; $display("FAIL rm_fresh_idx got %0d want 2", bus.out_plane_idx); end
    total++; if (bus.out_p !== 4'b1010) begin bad++; $display("FAIL rm_fresh_p got %b want 1010", bus.out_p); end
    repeat (OUT_BITS) @(posedge clk);
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rm_drain got %b want 0", bus.out_valid); end
  endtask

  initial begin
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_extremes();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
